// File: rtl/rv_lsu.sv
// Load/store unit: one request per valid/ready handshake, request/ack memory port with byte
// strobes, and a response channel carrying extended load data or an error code.
module rv_lsu #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     MEM_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'('h8000_0000),
  parameter int unsigned     TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_store,
  input  logic [2:0]                   req_fun3,
  input  logic [XLEN-1:0]              req_addr,
  input  logic [XLEN-1:0]              req_wdata,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [XLEN/8-1:0]            mem_wstrb,
  output logic [XLEN-1:0]              mem_wdata,
  input  logic                         mem_ack,
  input  logic [XLEN-1:0]              mem_rdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [XLEN-1:0]              resp_data,
  output logic [1:0]                   resp_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_inc;
  logic            store_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [LW-1:0]   lane_q;

  logic            illegal, out_of_range, misaligned, bad;
  logic [XLEN-1:0] offset, widx;
  logic [2:0]      amask;
  logic [7:0]      smask;
  logic [15:0]     strb_full;
  logic [NB-1:0]   strb;
  logic [XLEN-1:0] rep;
  logic [XLEN-1:0] shifted, ext;
  logic            sbit;
  int              nbits;
  logic            timed_out;

  // Request classification, evaluated combinationally on the incoming request
  always_comb begin
    illegal = (req_fun3 == 3'b111) || (req_store && req_fun3[2]) ||
              ((XLEN == 32) && (req_fun3[1:0] == 2'b11 || req_fun3 == 3'b110));
    offset = req_addr - BASE_ADDR;
    widx = offset >> LW;
    out_of_range = (req_addr < BASE_ADDR) || (widx >= XLEN'(MEM_WORDS));
    case (req_fun3[1:0])
      2'd0:    begin amask = 3'd0; smask = 8'h01; end
      2'd1:    begin amask = 3'd1; smask = 8'h03; end
      2'd2:    begin amask = 3'd3; smask = 8'h0f; end
      default: begin amask = 3'd7; smask = 8'hff; end
    endcase
    misaligned = (req_addr[2:0] & amask) != 3'd0;
    bad = illegal || out_of_range || misaligned;
    strb_full = {8'h00, smask} << req_addr[LW-1:0];
    strb = strb_full[NB-1:0];
    rep = '0;
    for (int i = 0; i < int'(NB); i++) begin
      rep[8*i +: 8] = req_wdata[8*(i & int'(amask)) +: 8];
    end
  end

  // Load data extraction from the latched lane and size
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[XLEN-1];
    endcase
    nbits = 8 << size_q;
    ext = '0;
    for (int k = 0; k < int'(XLEN); k++) begin
      ext[k] = (k < nbits) ? shifted[k] : (!uns_q && sbit);
    end
  end

  assign cnt_inc   = cnt_q + 8'd1;
  assign timed_out = (cnt_inc == 8'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = bad ? StResp : StMem;
      StMem:   if (mem_ack || timed_out) state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_err  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            store_q   <= req_store;
            uns_q     <= req_fun3[2];
            size_q    <= req_fun3[1:0];
            lane_q    <= req_addr[LW-1:0];
            cnt_q     <= '0;
            resp_data <= '0;
            if (bad) begin
              resp_err <= (illegal || out_of_range) ? 2'd2 : 2'd1;
            end else begin
              resp_err  <= 2'd0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= widx[AW-1:0];
              mem_wstrb <= req_store ? strb : '1;
              mem_wdata <= rep;
            end
          end
        end
        StMem: begin
          // Ack wins over a timeout expiring in the same cycle
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            resp_err  <= 2'd0;
            resp_data <= store_q ? '0 : ext;
          end else if (timed_out) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            resp_err  <= 2'd3;
            resp_data <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_data <= '0;
            resp_err  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: a 32-bit instance for most vectors and a 64-bit instance for
// doubleword and word-unsigned loads; sel64 routes the shared stimulus to one of them.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_store, resp_ready, mem_ack, sel64;
  logic [2:0]  req_fun3;
  logic [63:0] req_addr, req_wdata, mem_rdata;

  logic        v32, v64, rr32, rr64, ack32, ack64;
  logic        r32_ready, r32_mreq, r32_we, r32_rvalid;
  logic [11:0] r32_maddr;
  logic [3:0]  r32_strb;
  logic [31:0] r32_wdata, r32_rdata;
  logic [1:0]  r32_err;
  logic        r64_ready, r64_mreq, r64_we, r64_rvalid;
  logic [11:0] r64_maddr;
  logic [7:0]  r64_strb;
  logic [63:0] r64_wdata, r64_rdata;
  logic [1:0]  r64_err;

  logic        o_req_ready, o_mem_req, o_mem_we, o_resp_valid;
  logic [63:0] o_mem_addr, o_mem_wdata, o_resp_data;
  logic [7:0]  o_strb;
  logic [1:0]  o_err;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  assign v32   = req_valid & ~sel64;
  assign v64   = req_valid & sel64;
  assign rr32  = resp_ready & ~sel64;
  assign rr64  = resp_ready & sel64;
  assign ack32 = mem_ack & ~sel64;
  assign ack64 = mem_ack & sel64;

  rv_lsu #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(r32_ready), .req_store(req_store),
    .req_fun3(req_fun3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .mem_req(r32_mreq), .mem_we(r32_we), .mem_addr(r32_maddr), .mem_wstrb(r32_strb),
    .mem_wdata(r32_wdata), .mem_ack(ack32), .mem_rdata(mem_rdata[31:0]),
    .resp_valid(r32_rvalid), .resp_ready(rr32), .resp_data(r32_rdata), .resp_err(r32_err)
  );

  rv_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(r64_ready), .req_store(req_store),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(r64_mreq), .mem_we(r64_we), .mem_addr(r64_maddr), .mem_wstrb(r64_strb),
    .mem_wdata(r64_wdata), .mem_ack(ack64), .mem_rdata(mem_rdata),
    .resp_valid(r64_rvalid), .resp_ready(rr64), .resp_data(r64_rdata), .resp_err(r64_err)
  );

  always_comb begin
    if (sel64) begin
      o_req_ready = r64_ready; o_mem_req = r64_mreq; o_mem_we = r64_we;
      o_resp_valid = r64_rvalid; o_mem_addr = {52'd0, r64_maddr}; o_mem_wdata = r64_wdata;
      o_resp_data = r64_rdata; o_strb = r64_strb; o_err = r64_err;
    end else begin
      o_req_ready = r32_ready; o_mem_req = r32_mreq; o_mem_we = r32_we;
      o_resp_valid = r32_rvalid; o_mem_addr = {52'd0, r32_maddr};
      o_mem_wdata = {32'd0, r32_wdata}; o_resp_data = {32'd0, r32_rdata};
      o_strb = {4'd0, r32_strb}; o_err = r32_err;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    req_store = st; req_fun3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".vld_after"}, 64'(o_resp_valid), 64'd0);
    check({tag, ".rdy_after"}, 64'(o_req_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input logic exp_mem, input logic [63:0] e_addr, input logic [7:0] e_strb,
                        input logic [63:0] e_wdata, input logic [1:0] e_err,
                        input logic [63:0] e_data);
    issue(st, f3, a, wd);
    if (exp_mem) begin
      check({tag, ".mreq"}, 64'(o_mem_req), 64'd1);
      check({tag, ".we"}, 64'(o_mem_we), 64'(st));
      check({tag, ".maddr"}, o_mem_addr, e_addr);
      check({tag, ".strb"}, 64'(o_strb), 64'(e_strb));
      if (st) check({tag, ".mwdata"}, o_mem_wdata, e_wdata);
      mem_rdata = rd; mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    check({tag, ".mreq_off"}, 64'(o_mem_req), 64'd0);
    check({tag, ".vld"}, 64'(o_resp_valid), 64'd1);
    check({tag, ".err"}, 64'(o_err), 64'(e_err));
    check({tag, ".data"}, o_resp_data, e_data);
    handshake(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; resp_ready = 1'b0; mem_ack = 1'b0;
    sel64 = 1'b0; req_fun3 = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.ready", 64'(o_req_ready), 64'd1);
    check("rst.mreq", 64'(o_mem_req), 64'd0);
    check("rst.vld", 64'(o_resp_valid), 64'd0);
    check("rst.strb", 64'(o_strb), 64'd0);
    check("rst.maddr", o_mem_addr, 64'd0);
    check("rst.err", 64'(o_err), 64'd0);

    run_op("sb", 1, 3'b000, 64'h8000_0005, 64'hAB, 0, 1, 1, 8'h02, 64'hABAB_ABAB, 0, 0);
    run_op("sh", 1, 3'b001, 64'h8000_0006, 64'h1234, 0, 1, 1, 8'h0C, 64'h1234_1234, 0, 0);
    run_op("sw", 1, 3'b010, 64'h8000_0008, 64'hDEAD_BEEF, 0, 1, 2, 8'h0F, 64'hDEAD_BEEF,
           0, 0);
    run_op("lb", 0, 3'b000, 64'h8000_0003, 0, 64'h8000_0000, 1, 0, 8'h0F, 0, 0,
           64'hFFFF_FF80);
    run_op("lbu", 0, 3'b100, 64'h8000_0003, 0, 64'h8000_0000, 1, 0, 8'h0F, 0, 0, 64'h80);
    run_op("lh", 0, 3'b001, 64'h8000_0002, 0, 64'h8001_0000, 1, 0, 8'h0F, 0, 0,
           64'hFFFF_8001);
    run_op("lhu", 0, 3'b101, 64'h8000_0002, 0, 64'h8001_0000, 1, 0, 8'h0F, 0, 0, 64'h8001);
    run_op("lw_last", 0, 3'b010, 64'h8000_3FFC, 0, 64'hCAFE_F00D, 1, 64'hFFF, 8'h0F, 0, 0,
           64'hCAFE_F00D);
    run_op("lw_mis", 0, 3'b010, 64'h8000_0002, 0, 0, 0, 0, 0, 0, 1, 0);
    run_op("lw_oor", 0, 3'b010, 64'h8000_4000, 0, 0, 0, 0, 0, 0, 2, 0);
    run_op("lw_low", 0, 3'b010, 64'h7FFF_FFFC, 0, 0, 0, 0, 0, 0, 2, 0);
    run_op("f111", 0, 3'b111, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 2, 0);
    run_op("st_u", 1, 3'b100, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 2, 0);
    run_op("ld32", 0, 3'b011, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 2, 0);
    run_op("prio", 0, 3'b001, 64'h8000_4001, 0, 0, 0, 0, 0, 0, 2, 0);

    // Timeout, then hold the error response under backpressure
    issue(0, 3'b010, 64'h8000_0010, 0);
    hi = 0;
    for (int i = 0; i < 40 && !o_resp_valid; i++) begin
      if (o_mem_req) hi++;
      @(posedge clk); #1;
    end
    check("to.req_cycles", 64'(hi), 64'd15);
    check("to.vld", 64'(o_resp_valid), 64'd1);
    check("to.err", 64'(o_err), 64'd3);
    check("to.mreq", 64'(o_mem_req), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.vld", 64'(o_resp_valid), 64'd1);
      check("bp.err", 64'(o_err), 64'd3);
      check("bp.data", o_resp_data, 64'd0);
      check("bp.ready", 64'(o_req_ready), 64'd0);
    end
    handshake("bp");

    // Ack in the cycle the counter reaches TIMEOUT is a success
    issue(0, 3'b010, 64'h8000_0014, 0);
    repeat (14) @(posedge clk);
    #1;
    check("edge.mreq", 64'(o_mem_req), 64'd1);
    mem_rdata = 64'h1234_5678; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("edge.vld", 64'(o_resp_valid), 64'd1);
    check("edge.err", 64'(o_err), 64'd0);
    check("edge.data", o_resp_data, 64'h1234_5678);
    handshake("edge");

    // Reset while waiting on memory
    issue(0, 3'b010, 64'h8000_0010, 0);
    check("rmid.mreq", 64'(o_mem_req), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rmid.mreq_off", 64'(o_mem_req), 64'd0);
    check("rmid.vld", 64'(o_resp_valid), 64'd0);
    check("rmid.ready", 64'(o_req_ready), 64'd1);
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    check("rmid.vld_late", 64'(o_resp_valid), 64'd0);

    sel64 = 1'b1;
    run_op("ld64", 0, 3'b011, 64'h8000_0008, 0, 64'h8000_0000_0000_0001, 1, 1, 8'hFF, 0, 0,
           64'h8000_0000_0000_0001);
    run_op("lwu64", 0, 3'b110, 64'h8000_000C, 0, 64'h8000_0000_0000_0001, 1, 1, 8'hFF, 0, 0,
           64'h0000_0000_8000_0000);
    run_op("lw64", 0, 3'b010, 64'h8000_000C, 0, 64'h8000_0000_0000_0001, 1, 1, 8'hFF, 0, 0,
           64'hFFFF_FFFF_8000_0000);
    run_op("sh64", 1, 3'b001, 64'h8000_000E, 64'hBEEF, 0, 1, 1, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF,
           0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
